// File: rtl/sec_pair_counter_pkg.sv
// sec_pair_pkg: shared types and default limits for the seconds/minutes pair counter
package sec_pair_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, REPEAT} rpt_state_t;
  typedef logic [3:0] bcd_t;
  localparam int DEF_UNITS_MAX     = 9;
  localparam int DEF_TENS_MAX      = 5;
  localparam int DEF_REPEAT_DELAY  = 50;
  localparam int DEF_REPEAT_PERIOD = 10;
endpackage

// File: rtl/sec_pair_counter_if.sv
// sec_pair_counter_if: button levels in, BCD digits and carry/borrow out
interface sec_pair_counter_if;
  import sec_pair_pkg::*;
  logic add;
  logic sub;
  bcd_t units_q;
  bcd_t tens_q;
  bcd_t units_qr;
  bcd_t tens_qr;
  logic carry;
  logic borrow;
  modport master (output add, sub, input units_q, tens_q, units_qr, tens_qr, carry, borrow);
  modport slave (input add, sub, output units_q, tens_q, units_qr, tens_qr, carry, borrow);
endinterface

// File: rtl/sec_pair_counter_bcd_wrap_digit.sv
// bcd_wrap_digit: one BCD digit register wrapping between 0 and MAX
module bcd_wrap_digit
  import sec_pair_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output bcd_t q,
  output bcd_t qr,
  output logic wrap
);
  bcd_t r_q;
  // digit steps up or down and wraps at the range ends
  always_ff @(posedge clk)
    r_q <= rst ? '0
         : inc ? (r_q == bcd_t'(MAX) ? '0 : r_q + 4'd1)
         : dec ? (r_q == '0 ? bcd_t'(MAX) : r_q - 4'd1)
         : r_q;
  assign q    = r_q;
  assign qr   = ~r_q;
  assign wrap = (inc & (r_q == bcd_t'(MAX))) | (dec & (r_q == '0));
endmodule

// File: rtl/sec_pair_counter.sv
// sec_pair_counter: two-digit BCD field with edge-stepped add/sub; SEC_PAIR_REPEAT_EN adds hold auto-repeat
module sec_pair_counter
  import sec_pair_pkg::*;
#(
  parameter int UNITS_MAX     = DEF_UNITS_MAX,
  parameter int TENS_MAX      = DEF_TENS_MAX,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic clk,
  input logic rst,
  sec_pair_counter_if.slave io_bus
);
  logic r_add_d, r_sub_d, r_carry, r_borrow;
  logic w_edge_up, w_edge_dn, w_up, w_dn, w_units_wrap, w_tens_wrap;

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || UNITS_MAX > 9 || TENS_MAX > 9) begin : g_bad_cfg
    $error("sec_pair_counter: invalid limit or repeat parameters");
  end

  assign w_edge_up = io_bus.add & ~r_add_d & ~io_bus.sub;
  assign w_edge_dn = io_bus.sub & ~r_sub_d & ~io_bus.add;

`ifdef SEC_PAIR_REPEAT_EN
  localparam int RPT_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = RPT_MAX > 1 ? $clog2(RPT_MAX) : 1;
  rpt_state_t r_state;
  logic r_dir_up;
  logic [CW-1:0] r_cnt;
  logic w_held, w_rpt;
  assign w_held = r_dir_up ? (io_bus.add & ~io_bus.sub) : (io_bus.sub & ~io_bus.add);
  assign w_rpt  = w_held & (((r_state == ARMED) & (r_cnt == CW'(REPEAT_DELAY - 1)))
                         | ((r_state == REPEAT) & (r_cnt == CW'(REPEAT_PERIOD - 1))));
  assign w_up   = w_edge_up | (w_rpt & r_dir_up);
  assign w_dn   = w_edge_dn | (w_rpt & ~r_dir_up);
  // repeat FSM: arm on a fresh edge, fire after the delay, then every period while held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dir_up <= 1'b0;
    end else if (w_edge_up | w_edge_dn) begin
      r_state  <= ARMED;
      r_cnt    <= '0;
      r_dir_up <= w_edge_up;
    end else if (r_state == IDLE || !w_held) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (w_rpt) begin
      r_state <= REPEAT;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_up = w_edge_up;
  assign w_dn = w_edge_dn;
`endif

  bcd_wrap_digit #(.MAX(UNITS_MAX)) u_units (
    .clk(clk), .rst(rst), .inc(w_up), .dec(w_dn),
    .q(io_bus.units_q), .qr(io_bus.units_qr), .wrap(w_units_wrap)
  );
  bcd_wrap_digit #(.MAX(TENS_MAX)) u_tens (
    .clk(clk), .rst(rst), .inc(w_up & w_units_wrap), .dec(w_dn & w_units_wrap),
    .q(io_bus.tens_q), .qr(io_bus.tens_qr), .wrap(w_tens_wrap)
  );

  // input history for edge detection and registered field wrap pulses
  always_ff @(posedge clk) begin
    r_add_d  <= rst ? 1'b0 : io_bus.add;
    r_sub_d  <= rst ? 1'b0 : io_bus.sub;
    r_carry  <= rst ? 1'b0 : w_up & w_tens_wrap;
    r_borrow <= rst ? 1'b0 : w_dn & w_tens_wrap;
  end

  assign io_bus.carry  = r_carry;
  assign io_bus.borrow = r_borrow;
endmodule

// File: tb/tb_sec_pair_counter.sv
// tb_sec_pair_counter: randomized and directed checks against a value-level model (SEC_PAIR_REPEAT_EN aware)
module tb_sec_pair_counter;
  import sec_pair_pkg::*;
  localparam int U = DEF_UNITS_MAX;
  localparam int T = DEF_TENS_MAX;
  localparam int D = DEF_REPEAT_DELAY;
  localparam int P = DEF_REPEAT_PERIOD;
  localparam int N = (U + 1) * (T + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sec_pair_counter_if io ();
  sec_pair_counter #(.UNITS_MAX(U), .TENS_MAX(T), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .io_bus(io)
  );

  int errors = 0;
  int checks = 0;
  int m_val = 0;
  bit m_carry, m_borrow, m_pa, m_ps, m_hup;
  int m_hk = -1;

  logic [17:0] got;
  assign got = {io.tens_q, io.units_q, io.tens_qr, io.units_qr, io.carry, io.borrow};

  function automatic logic [17:0] exp_vec();
    logic [3:0] u, t;
    u = 4'(m_val % (U + 1));
    t = 4'(m_val / (U + 1));
    return {t, u, ~t, ~u, m_carry, m_borrow};
  endfunction

  function automatic int dut_val();
    return int'(io.tens_q) * (U + 1) + int'(io.units_q);
  endfunction

  task automatic tick(input bit a, input bit s, input bit r);
    bit eu, ed, up, dn;
    io.add = a;
    io.sub = s;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_val = 0; m_carry = 0; m_borrow = 0; m_pa = 0; m_ps = 0; m_hk = -1;
    end else begin
      eu = a && !m_pa && !s;
      ed = s && !m_ps && !a;
      up = eu;
      dn = ed;
`ifdef SEC_PAIR_REPEAT_EN
      if (eu || ed) begin
        m_hk = 0;
        m_hup = eu;
      end else if (m_hk >= 0 && (m_hup ? (a && !s) : (s && !a))) m_hk++;
      else m_hk = -1;
      if (!(eu || ed) && m_hk >= D && (m_hk - D) % P == 0) begin
        up = m_hup;
        dn = !m_hup;
      end
`endif
      m_carry = up && m_val == N - 1;
      m_borrow = dn && m_val == 0;
      if (up) m_val = (m_val + 1) % N;
      if (dn) m_val = (m_val + N - 1) % N;
      m_pa = a;
      m_ps = s;
    end
  endtask

  task automatic goto_val(input int v);
    tick(0, 0, 1);
    repeat (v) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
    end
  endtask

  task automatic test_reset();
    tick(0, 0, 1);
    tick(0, 0, 1);
    checks++;
    if (got !== exp_vec()) begin errors++; $display("FAIL reset got=%h exp=%h", got, exp_vec()); end
    checks++;
    if ({io.tens_qr, io.units_qr} !== 8'hFF) begin errors++; $display("FAIL reset_qr got=%h exp=ff", {io.tens_qr, io.units_qr}); end
  endtask

  task automatic test_count_up();
    int n_carry = 0;
    tick(0, 0, 1);
    for (int i = 0; i < N; i++) begin
      tick(1, 0, 0);
      n_carry += int'(io.carry);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL count_up[%0d] got=%h exp=%h", i, got, exp_vec()); end
      tick(0, 0, 0);
      n_carry += int'(io.carry);
    end
    checks++;
    if (n_carry != 1 || dut_val() != 0) begin errors++; $display("FAIL carry_once got carries=%0d val=%0d exp 1/0", n_carry, dut_val()); end
  endtask

  task automatic test_borrow();
    tick(0, 0, 1);
    tick(0, 1, 0);
    checks++;
    if (got !== exp_vec() || io.borrow !== 1'b1) begin errors++; $display("FAIL borrow_wrap got=%h exp=%h", got, exp_vec()); end
    tick(0, 0, 0);
    checks++;
    if (got !== exp_vec()) begin errors++; $display("FAIL borrow_drop got=%h exp=%h", got, exp_vec()); end
    tick(0, 1, 0);
    checks++;
    if (got !== exp_vec() || dut_val() != N - 2) begin errors++; $display("FAIL borrow_next got=%h exp=%h", got, exp_vec()); end
  endtask

  task automatic test_digit_wrap();
    goto_val(U);
    tick(1, 0, 0);
    checks++;
    if (got !== exp_vec() || dut_val() != U + 1) begin errors++; $display("FAIL units_into_tens got=%h exp=%h", got, exp_vec()); end
    tick(0, 0, 0);
    tick(0, 1, 0);
    checks++;
    if (got !== exp_vec() || dut_val() != U) begin errors++; $display("FAIL tens_into_units got=%h exp=%h", got, exp_vec()); end
  endtask

  task automatic test_hold();
    int steps = 0;
    int prev;
    int want;
`ifdef SEC_PAIR_REPEAT_EN
    want = 16;
`else
    want = 1;
`endif
    tick(0, 0, 1);
    prev = dut_val();
    for (int i = 0; i < 200; i++) begin
      tick(1, 0, 0);
      if (dut_val() != prev) steps++;
      prev = dut_val();
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL hold[%0d] got=%h exp=%h", i, got, exp_vec()); end
    end
    tick(0, 0, 0);
    checks++;
    if (steps != want) begin errors++; $display("FAIL hold_steps got=%0d exp=%0d", steps, want); end
  endtask

  task automatic test_both();
    goto_val(23);
    tick(1, 1, 0);
    checks++;
    if (got !== exp_vec() || dut_val() != 23) begin errors++; $display("FAIL both_high got=%h exp=%h", got, exp_vec()); end
    tick(0, 0, 0);
  endtask

  task automatic test_rst_step();
    goto_val(37);
    tick(1, 0, 1);
    checks++;
    if (got !== exp_vec() || dut_val() != 0 || io.carry !== 1'b0) begin errors++; $display("FAIL rst_over_step got=%h exp=%h", got, exp_vec()); end
    tick(0, 0, 0);
  endtask

  task automatic test_hold_across_rst();
    goto_val(5);
    tick(1, 0, 0);
    tick(1, 0, 1);
    tick(1, 0, 0);
    checks++;
    if (got !== exp_vec() || dut_val() != 1) begin errors++; $display("FAIL hold_rst_step got=%h exp=%h", got, exp_vec()); end
    for (int i = 0; i < 80; i++) begin
      tick(1, 0, 0);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL hold_rst_rpt[%0d] got=%h exp=%h", i, got, exp_vec()); end
    end
    tick(0, 0, 0);
  endtask

  task automatic test_random();
    bit a = 0, s = 0, r;
    tick(0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) a = ~a;
      if ($urandom_range(0, 5) == 0) s = ~s;
      r = ($urandom_range(0, 149) == 0);
      tick(a, s, r);
      checks++;
      if (got !== exp_vec()) begin errors++; $display("FAIL random[%0d] got=%h exp=%h", i, got, exp_vec()); end
    end
  endtask

  initial begin
    io.add = 1'b0;
    io.sub = 1'b0;
    test_reset();
    test_count_up();
    test_borrow();
    test_digit_wrap();
    test_hold();
    test_both();
    test_rst_step();
    test_hold_across_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
